// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding,
// sequencer states, counter width and small decode helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // Wide enough for latencies up to 15 cycles.
  localparam int CNT_W = 4;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generation for the multiply/divide unit.
// Produces the 64-bit {hi,lo} value for the latched operation:
// product for mult/multu, {remainder,quotient} for div/divu.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  md_op_e      op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] divisor_s;
  logic [31:0] divisor_u;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic        div_ovf;

  assign div_zero = (op_b == 32'd0);

  // The only signed overflow case is INT_MIN / -1; dividing by 1 instead
  // yields exactly the architectural answer (quotient INT_MIN, remainder 0)
  // and keeps the divider away from the undefined input.
  assign div_ovf   = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign divisor_s = (div_zero || div_ovf) ? 32'd1 : op_b;
  assign divisor_u = div_zero ? 32'd1 : op_b;

  // Signed and unsigned products, both computed at full 64-bit width.
  always_comb begin
    prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    prod_u = {32'd0, op_a} * {32'd0, op_b};
  end

  // Quotient truncates toward zero; remainder carries the dividend's sign.
  always_comb begin
    quot_s = $signed(op_a) / $signed(divisor_s);
    rem_s  = $signed(op_a) % $signed(divisor_s);
    quot_u = op_a / divisor_u;
    rem_u  = op_a % divisor_u;
  end

  // Select the result matching the latched operation.
  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quot_s};
      MD_DIVU:  result = {rem_u, quot_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// Latches operands on start, models the fixed operation latency with a
// down-counter, owns HI/LO and requests a D-stage stall on conflicts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no operation in flight; accepts start, mthi/mtlo write here
// ST_MUL  | mult/multu in flight, counter counts down to terminal count
// ST_DIV  | div/divu in flight, counter counts down to terminal count
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic             tc;

  md_op_e           op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic             load_ops;
  logic             wr_result;
  logic             wr_hi;
  logic             wr_lo;

  logic [63:0]      result;
  logic             div_zero;

  assign tc = (cnt_q == '0);

  mdu_arith u_arith (
    .op_a     (a_q),
    .op_b     (b_q),
    .op       (op_q),
    .result   (result),
    .div_zero (div_zero)
  );

  // State register, latency counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state and counter: start is only honoured in IDLE, so a start
  // arriving while busy leaves the counter untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && op_is_mul(md_op)) begin
          state_d = ST_MUL;
          cnt_d   = MULT_LOAD;
        end else if (start && op_is_div(md_op)) begin
          state_d = ST_DIV;
          cnt_d   = DIV_LOAD;
        end
      end
      ST_MUL, ST_DIV: begin
        if (tc) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: datapath enables and the hazard stall request.
  always_comb begin
    load_ops  = 1'b0;
    wr_result = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ops = start && (op_is_mul(md_op) || op_is_div(md_op));
        wr_hi    = start && (md_op == MD_MTHI);
        wr_lo    = start && (md_op == MD_MTLO);
      end
      ST_MUL:  wr_result = tc;
      ST_DIV:  wr_result = tc && !div_zero;
      default: wr_result = 1'b0;
    endcase
    stall = d_md_use && (start || busy_q);
  end

  // Operand latches and HI/LO; results come only from latched operands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (load_ops) begin
        op_q <= md_op_e'(md_op);
        a_q  <= rs_val;
        b_q  <= rt_val;
      end
      if (wr_result) begin
        hi_q <= result[63:32];
        lo_q <= result[31:0];
      end else begin
        if (wr_hi) hi_q <= rs_val;
        if (wr_lo) lo_q <= rs_val;
      end
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: a remaining-cycles model of the
// unit is compared against the DUT every cycle, and directed scenarios pin
// the model with hand-computed values.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        d_md_use = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result computed up front, applied when the
  // remaining-cycle count runs out.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  bit          p_write;
  int          m_left = 0;
  bit          m_valid = 0;
  longint      sa, sb, sq, sr;
  logic [63:0] up;

  always @(posedge clk) begin
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_valid = 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_write) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start) begin
      sa = longint'($signed(rs_val));
      sb = longint'($signed(rt_val));
      case (md_op)
        3'd1: begin
          sq = sa * sb;
          p_hi = sq[63:32]; p_lo = sq[31:0]; p_write = 1; m_left = MC;
        end
        3'd2: begin
          up = {32'd0, rs_val} * {32'd0, rt_val};
          p_hi = up[63:32]; p_lo = up[31:0]; p_write = 1; m_left = MC;
        end
        3'd3: begin
          p_write = (rt_val != 0); m_left = DC;
          if (p_write) begin
            sq = sa / sb; sr = sa % sb;
            p_lo = sq[31:0]; p_hi = sr[31:0];
          end
        end
        3'd4: begin
          p_write = (rt_val != 0); m_left = DC;
          if (p_write) begin
            p_lo = rs_val / rt_val; p_hi = rs_val % rt_val;
          end
        end
        3'd5: m_hi = rs_val;
        3'd6: m_lo = rs_val;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("stall", {31'd0, stall}, {31'd0, (d_md_use && (start || m_left > 0))});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then count busy and stall cycles until idle again.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, output int nbusy, output int nstall);
    md_op = op; rs_val = a; rt_val = b; start = 1'b1; d_md_use = use_d;
    nbusy = 0; nstall = 0;
    #1;
    if (stall) nstall++;
    @(posedge clk);
    #1;
    start = 1'b0; md_op = 3'd0; rs_val = $urandom; rt_val = $urandom;
    #1;
    while (busy && nbusy < 40) begin
      nbusy++;
      if (stall) nstall++;
      @(posedge clk);
      #2;
    end
    if (stall) nstall++;
    d_md_use = 1'b0;
    tick();
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    md_op = op; rs_val = v; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    chk("mt_busy", {31'd0, busy}, 32'd0);
    tick();
  endtask

  int nb, ns;

  initial begin
    // Reset held two edges with a MULT start pending.
    reset = 1'b0; start = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    tick(); tick();
    reset = 1'b1; start = 1'b0; md_op = 3'd0;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, ns);
    chk("mult_cycles", nb, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns);
    chk("div_cycles", nb, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'h0000_0001);

    run_op(3'd2, 32'h0001_0000, 32'h0003_0000, 1'b1, nb, ns);
    chk("multu_stall", ns, 32'd6);
    chk("multu_cycles", nb, 32'd5);
    chk("multu_hi", hi, 32'h0000_0003);
    chk("multu_lo", lo, 32'h0000_0000);

    run_op(3'd2, 32'd9, 32'd9, 1'b0, nb, ns);
    chk("nouse_stall", ns, 32'd0);
    chk("nouse_lo", lo, 32'd81);

    mt(3'd5, 32'h11);
    chk("mthi", hi, 32'h11);
    mt(3'd6, 32'h22);
    chk("mtlo", lo, 32'h22);
    run_op(3'd3, 32'd5, 32'd0, 1'b0, nb, ns);
    chk("div0_cycles", nb, 32'd10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    run_op(3'd4, 32'd5, 32'd0, 1'b0, nb, ns);
    chk("divu0_lo", lo, 32'h22);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, ns);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    run_op(3'd7, 32'd1, 32'd1, 1'b0, nb, ns);
    chk("inv_cycles", nb, 32'd0);

    // MTLO issued while a MULTU is in flight must be ignored.
    md_op = 3'd2; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
    tick();
    md_op = 3'd6; rs_val = 32'hDEAD; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("mtlo_busy_lo", lo, 32'd42);
    chk("mtlo_busy_hi", hi, 32'd0);

    // Reset during the third busy cycle of a DIV.
    mt(3'd5, 32'h55);
    md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick(); tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
